mem_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares one single-port `memory` instance between two requesters, e.g. instruction fetch (m0) and load/store unit (m1).
- Registers each granted request and issues it to the memory as a one-cycle strobe with the address held stable until `mem_done`.
- Returns read data and a one-cycle done pulse to the owning requester.
- A timeout converts accesses to unmapped addresses (memory `active`=0, so `mem_done` never rises) into an error response.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one single-port memory.
// Ports: clk, rst_n (async active-low); m0_*/m1_* requester buses (addr, wdata,
// wmask, level wstrobe/rstrobe in; rdata, done pulse, err out); mem_* memory
// bus (addr/wdata/wmask/strobes out, rdata/done in); busy = not idle.
module mem_arbiter #(
  parameter int          TIMEOUT   = 15,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wstrobe,
  input  logic        m0_rstrobe,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wstrobe,
  input  logic        m1_rstrobe,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        r_state;
  logic          r_last, r_grant, r_we;
  logic [31:0]   r_addr, r_wdata, r_rdata_q, r_hold0, r_hold1;
  logic [3:0]    r_wmask;
  logic [CW-1:0] r_cnt;
  logic          r_mem_ws, r_mem_rs, r_done0, r_done1, r_err0, r_err1;
  logic          w_req0, w_req1, w_pick, w_we, w_to;
  assign w_req0 = m0_wstrobe | m0_rstrobe;
  assign w_req1 = m1_wstrobe | m1_rstrobe;
  // on conflict the port that did not win last time goes next
  assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_we   = w_pick ? m1_wstrobe : m0_wstrobe;
  assign w_to   = r_cnt == CW'(TIMEOUT - 1);
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wmask   = r_wmask;
  assign mem_wstrobe = r_mem_ws;
  assign mem_rstrobe = r_mem_rs;
  assign m0_done = r_done0;
  assign m1_done = r_done1;
  assign m0_err  = r_err0;
  assign m1_err  = r_err1;
  // the owning port sees the live response register, the other keeps its last view
  assign m0_rdata = r_grant ? r_hold0 : r_rdata_q;
  assign m1_rdata = r_grant ? r_rdata_q : r_hold1;
  assign busy     = r_state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_rdata_q <= '0;
      r_hold0   <= '0;
      r_hold1   <= '0;
      r_cnt     <= '0;
      r_mem_ws  <= 1'b0;
      r_mem_rs  <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_mem_ws <= 1'b0;
      r_mem_rs <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      if (r_grant) r_hold1 <= r_rdata_q;
      else r_hold0 <= r_rdata_q;
      case (r_state)
        IDLE: if (w_req0 | w_req1) begin
          r_grant  <= w_pick;
          r_addr   <= w_pick ? m1_addr : m0_addr;
          r_wdata  <= w_pick ? m1_wdata : m0_wdata;
          r_wmask  <= w_pick ? m1_wmask : m0_wmask;
          r_we     <= w_we;
          r_mem_ws <= w_we;
          r_mem_rs <= ~w_we;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (mem_done | w_to) begin
          if (!r_we) r_rdata_q <= mem_done ? mem_rdata : ERR_RDATA;
          r_done0 <= ~r_grant;
          r_done1 <= r_grant;
          r_err0  <= ~r_grant & ~mem_done;
          r_err1  <= r_grant & ~mem_done;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RESP: begin
          r_last  <= r_grant;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_wstrobe = 1'b0, m0_rstrobe = 1'b0, m1_wstrobe = 1'b0, m1_rstrobe = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_done, m0_err, m1_done, m1_err, mem_wstrobe, mem_rstrobe, busy;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_wstrobe(m0_wstrobe), .m0_rstrobe(m0_rstrobe),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_wstrobe(m1_wstrobe), .m1_rstrobe(m1_rstrobe),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  logic [31:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;
  logic [31:0] w_tmp;
  always @(posedge clk) begin
    mem_done <= 1'b0;
    if (ld_en) mem[ld_idx] <= ld_val;
    if ((mem_wstrobe | mem_rstrobe) && mem_addr < 32'h1000) begin
      mem_done <= 1'b1;
      if (mem_wstrobe) begin
        w_tmp = mem[mem_addr[11:2]];
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) w_tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[mem_addr[11:2]] <= w_tmp;
      end else begin
        mem_rdata <= mem[mem_addr[11:2]];
      end
    end
  end
  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   rs_cnt = 0, ws_cnt = 0;
  logic prev_strb = 1'b0;
  always @(negedge clk) begin
    if (mem_rstrobe) rs_cnt <= rs_cnt + 1;
    if (mem_wstrobe) ws_cnt <= ws_cnt + 1;
    if (mem_rstrobe | mem_wstrobe) chk("strobe_b2b", 32'(prev_strb), 32'd0);
    prev_strb <= mem_rstrobe | mem_wstrobe;
    if (m0_done | m1_done) begin
      if (q.size() == 0) chk("unexpected_done", 32'({m1_done, m0_done}), 32'd0);
      else begin
        e = q.pop_front();
        chk("done_port", 32'({m1_done, m0_done}), e.port ? 32'd2 : 32'd1);
        chk("done_err", 32'(e.port ? m1_err : m0_err), 32'(e.err));
        if (e.chk_rd) chk("done_rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end
  task automatic push(input bit port, input logic [31:0] rd, input bit err, input bit chk_rd);
    exp_t x;
    x.port = port; x.rdata = rd; x.err = err; x.chk_rd = chk_rd;
    q.push_back(x);
  endtask
  task automatic access(input bit port, input bit we, input bit re, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] rd,
                        input bit err, input bit chk_rd, input int lat, input string tag);
    int n;
    if (port) begin m1_addr = addr; m1_wdata = wd; m1_wmask = wm; m1_wstrobe = we; m1_rstrobe = re; end
    else begin m0_addr = addr; m0_wdata = wd; m0_wmask = wm; m0_wstrobe = we; m0_rstrobe = re; end
    push(port, rd, err, chk_rd);
    n = 0;
    do begin @(negedge clk); n++; end while (!(port ? m1_done : m0_done) && n < lat + 20);
    chk(tag, n, lat);
    m0_wstrobe = 1'b0; m0_rstrobe = 1'b0; m1_wstrobe = 1'b0; m1_rstrobe = 1'b0;
    @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_strobes"}, 32'({mem_wstrobe, mem_rstrobe}), 32'd0);
    chk({tag, "_dones"}, 32'({m1_done, m0_done, m1_err, m0_err}), 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    int n, r0, w0;
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 10'd4; ld_val = 32'hCAFEF00D;
    @(negedge clk);
    ld_idx = 10'd2; ld_val = 32'hAAAAAAAA;
    @(negedge clk);
    ld_en = 1'b0;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // single read with cycle-exact strobe/done timing
    m0_addr = 32'h10; m0_rstrobe = 1'b1;
    push(1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
    @(negedge clk);
    chk("rd_c1_rstrobe", 32'(mem_rstrobe), 32'd1);
    chk("rd_c1_addr", mem_addr, 32'h10);
    chk("rd_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rd_c2_rstrobe", 32'(mem_rstrobe), 32'd0);
    @(negedge clk);
    chk("rd_c3_m0_done", 32'(m0_done), 32'd1);
    chk("rd_c3_m1_done", 32'(m1_done), 32'd0);
    m0_rstrobe = 1'b0;
    @(negedge clk);
    // masked write then readback
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'h12345678, 4'b0011, 32'h0, 1'b0, 1'b0, 3, "wr_lat");
    access(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 32'hAAAA5678, 1'b0, 1'b1, 3, "wr_rb_lat");
    // conflict from reset, then 8 alternating grants under continuous requests
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m0_addr = 32'h10; m0_rstrobe = 1'b1; m1_addr = 32'h8; m1_rstrobe = 1'b1;
    for (int i = 0; i < 8; i++) push(i[0], i[0] ? 32'hAAAA5678 : 32'hCAFEF00D, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("cf_c3_m0_done", 32'(m0_done), 32'd1);
    repeat (2) @(negedge clk);
    chk("cf_c5_rstrobe", 32'(mem_rstrobe), 32'd1);
    chk("cf_c5_addr", mem_addr, 32'h8);
    repeat (2) @(negedge clk);
    chk("cf_c7_m1_done", 32'(m1_done), 32'd1);
    n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    m0_rstrobe = 1'b0; m1_rstrobe = 1'b0;
    chk("cf_drain", q.size(), 32'd0);
    @(negedge clk);
    // timeout on unmapped address
    r0 = rs_cnt;
    access(1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 17, "to_lat");
    chk("to_rstrobe_count", rs_cnt - r0, 32'd1);
    // reset in the middle of a WAIT
    m1_addr = 32'h0001_0000; m1_rstrobe = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    m1_rstrobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, 3, "post_rst_lat");
    // both strobes high act as a write and leave rdata alone
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, 3, "pre_both_lat");
    r0 = rs_cnt; w0 = ws_cnt;
    access(1'b0, 1'b1, 1'b1, 32'h4, 32'h55, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 3, "both_lat");
    chk("both_wstrobes", ws_cnt - w0, 32'd1);
    chk("both_rstrobes", rs_cnt - r0, 32'd0);
    access(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 32'h00000055, 1'b0, 1'b1, 3, "both_rb_lat");
    repeat (3) @(negedge clk);
    chk("final_queue", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
